// File: rtl/lv2_bus_responder.sv
// rtl/lv2_bus_responder.sv - L2-side responder for the shared L1/L2 request bus
//
// Serves L1 read and write requests from a backing array. Reads are returned
// on the shared tristate data bus; writes complete with a lv2_wr_done pulse.
// A RELEASE cycle with every inout at Z separates any two bus transactions.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   addr_bus_lv1_lv2      request address (sampled only, never driven)
//   data_bus_lv1_lv2      write data in / read data out (driven only in R_DRIVE)
//   data_in_bus_lv1_lv2   read-data-valid (driven 1 only in R_DRIVE)
//   lv2_rd, lv2_wr        L1 read / write requests (level, held by L1)
//   cp_in_cache           a peer L1 supplies the line; reads are not served here
//   lv2_wr_done           write complete, held until lv2_wr drops
//   mem_rd, mem_wr        backing-array strobes, held until mem_ack
//   mem_addr, mem_wdata   registered backing-array request fields
//   mem_rdata, mem_ack    backing-array read data and 1-cycle completion pulse
//   busy, proto_err       not-IDLE flag, sticky protocol-error flag

`ifndef DATA_WID_LV1
`define DATA_WID_LV1 32
`endif
`ifndef ADDR_WID_LV1
`define ADDR_WID_LV1 32
`endif

module lv2_bus_responder #(
    parameter int DATA_WID = `DATA_WID_LV1,
    parameter int ADDR_WID = `ADDR_WID_LV1
) (
    input  logic                clk,
    input  logic                rst_n,
    inout  wire  [ADDR_WID-1:0] addr_bus_lv1_lv2,
    inout  wire  [DATA_WID-1:0] data_bus_lv1_lv2,
    input  logic                lv2_rd,
    input  logic                lv2_wr,
    input  logic                cp_in_cache,
    inout  wire                 data_in_bus_lv1_lv2,
    output logic                lv2_wr_done,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [ADDR_WID-1:0] mem_addr,
    output logic [DATA_WID-1:0] mem_wdata,
    input  logic [DATA_WID-1:0] mem_rdata,
    input  logic                mem_ack,
    output logic                busy,
    output logic                proto_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        R_WAIT  = 3'd1,
        R_DRIVE = 3'd2,
        W_WAIT  = 3'd3,
        W_DONE  = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t              state;
    logic [DATA_WID-1:0] rdata_q;
    logic                abort_q;    // requester withdrew while the array op was in flight
    logic                discard_q;  // a peer L1 took over the read; drop the array data

    // The bus is only ever driven from R_DRIVE; because state is reset
    // asynchronously, both drivers fall to Z as soon as rst_n goes low.
    assign data_bus_lv1_lv2    = (state == R_DRIVE) ? rdata_q : {DATA_WID{1'bz}};
    assign data_in_bus_lv1_lv2 = (state == R_DRIVE) ? 1'b1 : 1'bz;
    assign busy                = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rdata_q     <= '0;
            abort_q     <= 1'b0;
            discard_q   <= 1'b0;
            lv2_wr_done <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            proto_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    abort_q   <= 1'b0;
                    discard_q <= 1'b0;
                    // Write wins over a simultaneous read; the overlap is a
                    // protocol violation by the L1 side.
                    if (lv2_wr) begin
                        mem_addr  <= addr_bus_lv1_lv2;
                        mem_wdata <= data_bus_lv1_lv2;
                        mem_wr    <= 1'b1;
                        state     <= W_WAIT;
                        if (lv2_rd) begin
                            proto_err <= 1'b1;
                        end
                    end else if (lv2_rd && !cp_in_cache) begin
                        mem_addr <= addr_bus_lv1_lv2;
                        mem_rd   <= 1'b1;
                        state    <= R_WAIT;
                    end
                end

                R_WAIT: begin
                    // Entry requires cp_in_cache=0, so any 1 seen here is a rise.
                    // Once a peer owns the line, dropping lv2_rd is legitimate.
                    if (cp_in_cache) begin
                        discard_q <= 1'b1;
                    end else if (!lv2_rd && !discard_q) begin
                        abort_q   <= 1'b1;
                        proto_err <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_rd <= 1'b0;
                        if (discard_q || cp_in_cache) begin
                            state <= IDLE;
                        end else if (abort_q || !lv2_rd) begin
                            state <= RELEASE;
                        end else begin
                            rdata_q <= mem_rdata;
                            state   <= R_DRIVE;
                        end
                    end
                end

                R_DRIVE: begin
                    if (!lv2_rd) begin
                        state <= RELEASE;
                    end
                end

                W_WAIT: begin
                    if (!lv2_wr) begin
                        abort_q   <= 1'b1;
                        proto_err <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_wr <= 1'b0;
                        if (abort_q || !lv2_wr) begin
                            state <= RELEASE;
                        end else begin
                            lv2_wr_done <= 1'b1;
                            state       <= W_DONE;
                        end
                    end
                end

                W_DONE: begin
                    if (!lv2_wr) begin
                        lv2_wr_done <= 1'b0;
                        state       <= RELEASE;
                    end
                end

                RELEASE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lv2_bus_responder.sv
// tb/tb_lv2_bus_responder.sv - directed, table-driven bench for lv2_bus_responder

module tb_lv2_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_drv;
    logic [31:0] tb_wdata;
    logic        tb_oe;
    logic        lv2_rd, lv2_wr, cp_in_cache;
    logic        lv2_wr_done, mem_rd, mem_wr, busy, proto_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    wire  [31:0] addr_bus;
    tri1  [31:0] data_bus;
    tri0         data_in_bus;

    assign addr_bus = addr_drv;
    assign data_bus = tb_oe ? tb_wdata : 32'bz;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_lat = 1;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    lv2_bus_responder #(.DATA_WID(32), .ADDR_WID(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .addr_bus_lv1_lv2    (addr_bus),
        .data_bus_lv1_lv2    (data_bus),
        .lv2_rd              (lv2_rd),
        .lv2_wr              (lv2_wr),
        .cp_in_cache         (cp_in_cache),
        .data_in_bus_lv1_lv2 (data_in_bus),
        .lv2_wr_done         (lv2_wr_done),
        .mem_rd              (mem_rd),
        .mem_wr              (mem_wr),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .mem_ack             (mem_ack),
        .busy                (busy),
        .proto_err           (proto_err)
    );

    // Backing array: one ack pulse ack_lat cycles after a strobe is first seen.
    always @(posedge clk) begin
        if ((mem_rd || mem_wr) && !mem_ack) begin
            if (ack_cnt + 1 >= ack_lat) begin
                mem_ack <= 1'b1;
                ack_cnt <= 0;
            end else begin
                mem_ack <= 1'b0;
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            mem_ack <= 1'b0;
            ack_cnt <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int lat, input int exp_lat);
        int n = 0;
        ack_lat   = lat;
        mem_rdata = d;
        addr_drv  = a;
        lv2_rd    = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("rd_mem_rd", 32'(mem_rd), 32'd1);
                chk("rd_mem_addr", mem_addr, a);
                addr_drv = ~a;
            end
        end while (data_in_bus !== 1'b1 && n < 40);
        chk("rd_latency", 32'(n), 32'(exp_lat));
        chk("rd_data", data_bus, d);
        @(negedge clk);
        chk("rd_hold_valid", 32'(data_in_bus), 32'd1);
        chk("rd_mem_rd_fall", 32'(mem_rd), 32'd0);
        lv2_rd = 1'b0;
        @(negedge clk);
        chk("rd_release_valid", 32'(data_in_bus), 32'd0);
        chk("rd_release_data", data_bus, 32'hFFFF_FFFF);
        chk("rd_release_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rd_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat, input int exp_lat);
        int n = 0;
        ack_lat  = lat;
        addr_drv = a;
        tb_wdata = d;
        tb_oe    = 1'b1;
        lv2_wr   = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("wr_mem_wr", 32'(mem_wr), 32'd1);
                chk("wr_mem_addr", mem_addr, a);
                chk("wr_mem_wdata", mem_wdata, d);
                tb_oe    = 1'b0;
                addr_drv = ~a;
            end
        end while (lv2_wr_done !== 1'b1 && n < 40);
        chk("wr_latency", 32'(n), 32'(exp_lat));
        chk("wr_mem_wr_fall", 32'(mem_wr), 32'd0);
        @(negedge clk);
        chk("wr_done_hold", 32'(lv2_wr_done), 32'd1);
        lv2_wr = 1'b0;
        @(negedge clk);
        chk("wr_done_fall", 32'(lv2_wr_done), 32'd0);
        chk("wr_release_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("wr_idle_busy", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          exp_lat;
    } vec_t;

    vec_t vt[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic drove;

        vt[0] = '{1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 4, 6};
        vt[1] = '{1'b1, 32'h0000_0080, 32'h1234_5678, 1, 3};
        vt[2] = '{1'b0, 32'h0000_0044, 32'h0000_0001, 1, 3};
        vt[3] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 3, 5};
        vt[4] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFE, 2, 4};

        rst_n = 1'b0; lv2_rd = 1'b0; lv2_wr = 1'b0; cp_in_cache = 1'b0;
        addr_drv = 32'h0; tb_wdata = 32'h0; tb_oe = 1'b0; mem_rdata = 32'h0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_wr_done", 32'(lv2_wr_done), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_valid_z", 32'(data_in_bus), 32'd0);
        chk("rst_data_z", data_bus, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (vt[i].wr) do_write(vt[i].addr, vt[i].data, vt[i].lat, vt[i].exp_lat);
            else          do_read(vt[i].addr, vt[i].data, vt[i].lat, vt[i].exp_lat);
        end

        // Peer supplies the line while still in IDLE: nothing issued.
        lv2_rd = 1'b1; cp_in_cache = 1'b1; addr_drv = 32'h100;
        drove = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_rd || busy || data_in_bus === 1'b1) drove = 1'b1;
        end
        chk("cp_idle_no_issue", 32'(drove), 32'd0);
        lv2_rd = 1'b0; cp_in_cache = 1'b0;
        @(negedge clk);

        // Peer takes over during R_WAIT: wait out the ack, no drive, back to IDLE.
        ack_lat = 4; mem_rdata = 32'h5555_AAAA;
        lv2_rd = 1'b1;
        @(negedge clk);
        chk("cp_rwait_mem_rd", 32'(mem_rd), 32'd1);
        cp_in_cache = 1'b1;
        n = 0; drove = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (data_in_bus === 1'b1) drove = 1'b1;
        end while (busy && n < 30);
        chk("cp_rwait_cycles", 32'(n), 32'd5);
        chk("cp_rwait_no_drive", 32'(drove), 32'd0);
        chk("cp_rwait_mem_rd_fall", 32'(mem_rd), 32'd0);
        chk("cp_rwait_no_err", 32'(proto_err), 32'd0);
        lv2_rd = 1'b0; cp_in_cache = 1'b0;
        @(negedge clk);

        // Read and write together: treated as a write, sticky error.
        ack_lat = 1; addr_drv = 32'h200; tb_wdata = 32'hCAFE_F00D; tb_oe = 1'b1;
        lv2_rd = 1'b1; lv2_wr = 1'b1;
        @(negedge clk);
        chk("both_mem_wr", 32'(mem_wr), 32'd1);
        chk("both_mem_rd", 32'(mem_rd), 32'd0);
        chk("both_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("both_proto_err", 32'(proto_err), 32'd1);
        tb_oe = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!lv2_wr_done && n < 30);
        chk("both_wr_done", 32'(lv2_wr_done), 32'd1);
        lv2_rd = 1'b0; lv2_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("both_err_sticky", 32'(proto_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("both_err_cleared", 32'(proto_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Read withdrawn during R_WAIT: error, no drive, through RELEASE to IDLE.
        ack_lat = 3; addr_drv = 32'h300;
        lv2_rd = 1'b1;
        @(negedge clk);
        lv2_rd = 1'b0;
        n = 0; drove = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (data_in_bus === 1'b1) drove = 1'b1;
        end while (busy && n < 30);
        chk("wd_cycles", 32'(n), 32'd5);
        chk("wd_no_drive", 32'(drove), 32'd0);
        chk("wd_proto_err", 32'(proto_err), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted in R_DRIVE: bus released with no clock edge.
        ack_lat = 1; mem_rdata = 32'h0BAD_F00D; addr_drv = 32'h400;
        lv2_rd = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (data_in_bus !== 1'b1 && n < 30);
        chk("rstdrv_driving", data_bus, 32'h0BAD_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstdrv_valid_z", 32'(data_in_bus), 32'd0);
        chk("rstdrv_data_z", data_bus, 32'hFFFF_FFFF);
        chk("rstdrv_busy", 32'(busy), 32'd0);
        chk("rstdrv_mem_addr", mem_addr, 32'h0);
        lv2_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back read then write: exactly one RELEASE cycle in between.
        ack_lat = 1; mem_rdata = 32'h7777_1111; addr_drv = 32'h500;
        lv2_rd = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (data_in_bus !== 1'b1 && n < 30);
        chk("b2b_rd_data", data_bus, 32'h7777_1111);
        lv2_rd = 1'b0;
        @(negedge clk);
        chk("b2b_release_valid", 32'(data_in_bus), 32'd0);
        chk("b2b_release_busy", 32'(busy), 32'd1);
        addr_drv = 32'h600; tb_wdata = 32'h6666_0000; tb_oe = 1'b1; lv2_wr = 1'b1;
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_no_wr", 32'(mem_wr), 32'd0);
        @(negedge clk);
        chk("b2b_wr_issued", 32'(mem_wr), 32'd1);
        chk("b2b_wr_addr", mem_addr, 32'h600);
        chk("b2b_wr_data", mem_wdata, 32'h6666_0000);
        tb_oe = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!lv2_wr_done && n < 30);
        chk("b2b_wr_done", 32'(lv2_wr_done), 32'd1);
        lv2_wr = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_final_idle", 32'(busy), 32'd0);
        chk("b2b_no_err", 32'(proto_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
